// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Purpose:
//   Shares one FIFO write port between NREQ requesters. An idle arbiter picks
//   the next requester round-robin (starting after the last owner). The owner
//   then holds the write port for a burst of up to MAX_BURST beats. The burst
//   ends early if the owner drops req_valid. The burst stalls while the FIFO
//   reports full.
//
// Parameters:
//   NREQ       number of requesters
//   DWIDTH     data width
//   MAX_BURST  maximum beats per grant (1..255)
//
// Ports:
//   clk          in   single clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   req_valid    in   [NREQ]          per-requester data valid
//   req_data     in   [NREQ*DWIDTH]   requester i at [i*DWIDTH +: DWIDTH]
//   req_ready    out  [NREQ]          beat accepted this cycle (owner only)
//   write        out                  FIFO write strobe
//   din          out  [DWIDTH]        FIFO write data (0 when idle)
//   full         in                   FIFO full, stalls the burst
//   almost_full  in                   FIFO almost full (see macro below)
//   grant        out  [NREQ]          one-hot current owner, 0 when idle
//   busy         out                  high while a grant is active
//
// Build option:
//   FIFO_ARB_AFULL_EN  when defined, no new grant is issued while almost_full
//                      is high. A burst that is already running continues and
//                      is limited only by full. When undefined, almost_full
//                      is ignored.
//
// State table:
//   S_IDLE  | no owner; arbitrate among valid requesters
//   S_GRANT | owner holds the write port for up to MAX_BURST beats
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int DWIDTH    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*DWIDTH-1:0]   req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic                     write,
  output logic [DWIDTH-1:0]        din,
  input  logic                     full,
  input  logic                     almost_full,
  output logic [NREQ-1:0]          grant,
  output logic                     busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [7:0]    LAST_BEAT  = 8'(MAX_BURST - 1);
  localparam logic [IW-1:0] LAST_INDEX = IW'(NREQ - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [NREQ-1:0]   r_grant;
  logic [IW-1:0]     r_owner;
  logic [IW-1:0]     r_last_owner;
  logic [7:0]        r_beat_cnt;

  logic [DWIDTH-1:0] w_data_arr [NREQ];
  logic [IW-1:0]     w_pick_idx;
  logic              w_pick_found;
  int                w_rr_idx;
  logic              w_arb_block;
  logic              w_start;
  logic              w_owner_valid;
  logic              w_xfer;
  logic              w_end_burst;
  logic              w_release;

  // Unpack the flat data bus so the owner's word can be selected by index.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign w_data_arr[gi] = req_data[gi*DWIDTH +: DWIDTH];
  end

`ifdef FIFO_ARB_AFULL_EN
  assign w_arb_block = almost_full;
`else
  logic w_unused_afull;
  assign w_unused_afull = almost_full;
  assign w_arb_block    = 1'b0;
`endif

  // Round-robin search: first valid requester at last_owner+1, +2, ...
  // Offset NREQ wraps back to the last owner itself. That makes it the
  // lowest priority, so it still gets the grant when it is the only one
  // requesting.
  always_comb begin
    w_pick_found = 1'b0;
    w_pick_idx   = '0;
    w_rr_idx     = 0;
    for (int k = 1; k <= NREQ; k++) begin
      w_rr_idx = (int'(r_last_owner) + k) % NREQ;
      if (!w_pick_found && req_valid[w_rr_idx[IW-1:0]]) begin
        w_pick_found = 1'b1;
        w_pick_idx   = w_rr_idx[IW-1:0];
      end
    end
  end

  assign w_owner_valid = req_valid[r_owner];
  assign w_start       = (r_state == S_IDLE) && w_pick_found && !w_arb_block;
  assign w_xfer        = (r_state == S_GRANT) && w_owner_valid && !full;
  assign w_end_burst   = w_xfer && (r_beat_cnt == LAST_BEAT);
  // Owner leaves on a dropped valid (even during a full stall) or on its last beat.
  assign w_release     = (r_state == S_GRANT) && (!w_owner_valid || w_end_burst);

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM: next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start)   w_state_nxt = S_GRANT;
      S_GRANT: if (w_release) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Owner, round-robin pointer and beat counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant      <= '0;
      r_owner      <= '0;
      r_last_owner <= LAST_INDEX;
      r_beat_cnt   <= '0;
    end else if (w_start) begin
      r_grant    <= NREQ'(1) << w_pick_idx;
      r_owner    <= w_pick_idx;
      r_beat_cnt <= '0;
    end else if (w_release) begin
      r_grant      <= '0;
      r_last_owner <= r_owner;
      r_beat_cnt   <= '0;
    end else if (w_xfer) begin
      r_beat_cnt <= r_beat_cnt + 8'd1;
    end
  end

  // FSM: outputs. All outputs come straight from registered state and the
  // current inputs, so an asynchronous reset clears them at once.
  always_comb begin
    busy      = (r_state == S_GRANT);
    grant     = r_grant;
    write     = w_xfer;
    req_ready = w_xfer ? r_grant : '0;
    din       = (r_state == S_GRANT) ? w_data_arr[r_owner] : '0;
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;

  localparam int NREQ      = 4;
  localparam int DWIDTH    = 32;
  localparam int MAX_BURST = 4;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [NREQ-1:0]        req_valid = '0;
  logic [NREQ*DWIDTH-1:0] req_data = '0;
  logic [NREQ-1:0]        req_ready;
  logic                   write;
  logic [DWIDTH-1:0]      din;
  logic                   full = 1'b0;
  logic                   almost_full = 1'b0;
  logic [NREQ-1:0]        grant;
  logic                   busy;

  fifo_wr_arbiter #(.NREQ(NREQ), .DWIDTH(DWIDTH), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .write(write), .din(din), .full(full),
    .almost_full(almost_full), .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [DWIDTH-1:0] fixed_word(input int i);
    return 32'hD000_0000 + 32'(i) * 32'h0101_0111;
  endfunction

  function automatic logic [DWIDTH-1:0] oh_data(input logic [NREQ-1:0] oh);
    logic [DWIDTH-1:0] d;
    d = '0;
    for (int i = 0; i < NREQ; i++) if (oh[i]) d = fixed_word(i);
    return d;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0;
    full = 1'b0;
    almost_full = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  typedef struct {
    logic [NREQ-1:0] valid;
    logic            full;
    logic [NREQ-1:0] exp_grant;
    logic            exp_write;
    logic            exp_busy;
    logic [NREQ-1:0] exp_ready;
  } vec_t;

  vec_t vecs[15];

  // Reference model: owner index (-1 = nobody), beats taken, last owner.
  int m_owner, m_last, m_beats;

  initial begin
    // Directed cycle table: drop after 1 beat, round-robin resume, full stall,
    // wrap to requester 0, drop while full.
    vecs[0]  = '{4'b0100, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000};
    vecs[1]  = '{4'b0100, 1'b0, 4'b0100, 1'b1, 1'b1, 4'b0100};
    vecs[2]  = '{4'b0000, 1'b0, 4'b0100, 1'b0, 1'b1, 4'b0000};
    vecs[3]  = '{4'b1001, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000};
    vecs[4]  = '{4'b1001, 1'b0, 4'b1000, 1'b1, 1'b1, 4'b1000};
    vecs[5]  = '{4'b1001, 1'b1, 4'b1000, 1'b0, 1'b1, 4'b0000};
    vecs[6]  = '{4'b1001, 1'b1, 4'b1000, 1'b0, 1'b1, 4'b0000};
    vecs[7]  = '{4'b1001, 1'b0, 4'b1000, 1'b1, 1'b1, 4'b1000};
    vecs[8]  = '{4'b1001, 1'b0, 4'b1000, 1'b1, 1'b1, 4'b1000};
    vecs[9]  = '{4'b1001, 1'b0, 4'b1000, 1'b1, 1'b1, 4'b1000};
    vecs[10] = '{4'b1001, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000};
    vecs[11] = '{4'b1001, 1'b0, 4'b0001, 1'b1, 1'b1, 4'b0001};
    vecs[12] = '{4'b0000, 1'b1, 4'b0001, 1'b0, 1'b1, 4'b0000};
    vecs[13] = '{4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000};
    vecs[14] = '{4'b0001, 1'b0, 4'b0001, 1'b1, 1'b1, 4'b0001};

    // Reset values with all requesters asking
    @(posedge clk); #1;
    req_valid = '1;
    for (int i = 0; i < NREQ; i++) req_data[i*DWIDTH +: DWIDTH] = fixed_word(i);
    @(negedge clk);
    chk("rst_grant", 64'(grant), 64'(0));
    chk("rst_write", 64'(write), 64'(0));
    chk("rst_busy",  64'(busy),  64'(0));
    chk("rst_ready", 64'(req_ready), 64'(0));
    chk("rst_din",   64'(din),   64'(0));

    // Table-driven sequence
    do_reset();
    for (int v = 0; v < 15; v++) begin
      req_valid = vecs[v].valid;
      full = vecs[v].full;
      @(negedge clk);
      chk($sformatf("tbl%0d_grant", v), 64'(grant), 64'(vecs[v].exp_grant));
      chk($sformatf("tbl%0d_write", v), 64'(write), 64'(vecs[v].exp_write));
      chk($sformatf("tbl%0d_busy", v),  64'(busy),  64'(vecs[v].exp_busy));
      chk($sformatf("tbl%0d_ready", v), 64'(req_ready), 64'(vecs[v].exp_ready));
      chk($sformatf("tbl%0d_din", v),   64'(din),
          64'(vecs[v].exp_busy ? oh_data(vecs[v].exp_grant) : '0));
      @(posedge clk); #1;
    end

    // Single requester with counting data: 0..3, one idle cycle, 4..7
    begin
      int exp_w[10] = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 1};
      logic [DWIDTH-1:0] dcnt;
      do_reset();
      req_data = '0;
      req_valid = 4'b0001;
      dcnt = '0;
      for (int c = 0; c < 10; c++) begin
        req_data[DWIDTH-1:0] = dcnt;
        @(negedge clk);
        chk($sformatf("single_c%0d_write", c), 64'(write), 64'(exp_w[c]));
        if (exp_w[c] != 0) chk($sformatf("single_c%0d_din", c), 64'(din), 64'(dcnt));
        @(posedge clk); #1;
        if (exp_w[c] != 0) dcnt = dcnt + 1;
      end
      chk("single_total", 64'(dcnt), 64'(8));
    end

    // All four valid from reset: 4-beat bursts in order, 1 idle cycle between
    do_reset();
    for (int i = 0; i < NREQ; i++) req_data[i*DWIDTH +: DWIDTH] = fixed_word(i);
    req_valid = 4'b1111;
    for (int c = 0; c < 25; c++) begin
      logic [NREQ-1:0] eg;
      eg = (c % 5 == 0) ? '0 : NREQ'(1) << ((c / 5) % NREQ);
      @(negedge clk);
      chk($sformatf("rr_c%0d_grant", c), 64'(grant), 64'(eg));
      chk($sformatf("rr_c%0d_write", c), 64'(write), 64'(eg != '0));
      @(posedge clk); #1;
    end

    // almost_full held in idle for 3 cycles
    do_reset();
    req_valid = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      logic [NREQ-1:0] eg;
      almost_full = (c < 3);
`ifdef FIFO_ARB_AFULL_EN
      eg = (c < 4) ? '0 : 4'b0001;
`else
      eg = (c == 0) ? '0 : 4'b0001;
`endif
      @(negedge clk);
      chk($sformatf("afull_c%0d_grant", c), 64'(grant), 64'(eg));
      @(posedge clk); #1;
    end
    almost_full = 1'b0;

    // Asynchronous reset in the middle of a burst
    do_reset();
    req_valid = 4'b0001;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst_pre_write", 64'(write), 64'(1));
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_write", 64'(write), 64'(0));
    chk("midrst_grant", 64'(grant), 64'(0));
    chk("midrst_busy",  64'(busy),  64'(0));
    chk("midrst_ready", 64'(req_ready), 64'(0));
    @(posedge clk); #1;
    req_valid = 4'b1111;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_idle_grant", 64'(grant), 64'(0));
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst_first_grant", 64'(grant), 64'(4'b0001));
    @(posedge clk); #1;

    // Randomized run against the reference model
    do_reset();
    m_owner = -1; m_last = NREQ - 1; m_beats = 0;
    req_valid = '0;
    for (int c = 0; c < 800; c++) begin
      logic [NREQ-1:0]   e_grant, e_ready;
      logic              e_write, e_busy, blk;
      logic [DWIDTH-1:0] e_din;
      req_valid = req_valid ^ NREQ'($urandom_range(0, 15) & $urandom_range(0, 15));
      full = ($urandom_range(0, 4) == 0);
      almost_full = ($urandom_range(0, 2) == 0);
      for (int i = 0; i < NREQ; i++) req_data[i*DWIDTH +: DWIDTH] = $urandom;
      @(negedge clk);
      if (m_owner < 0) begin
        e_grant = '0; e_busy = 1'b0; e_write = 1'b0; e_din = '0;
      end else begin
        e_grant = NREQ'(1) << m_owner;
        e_busy  = 1'b1;
        e_write = req_valid[m_owner] && !full;
        e_din   = req_data[m_owner*DWIDTH +: DWIDTH];
      end
      e_ready = e_write ? e_grant : '0;
      chk($sformatf("rnd%0d_grant", c), 64'(grant), 64'(e_grant));
      chk($sformatf("rnd%0d_write", c), 64'(write), 64'(e_write));
      chk($sformatf("rnd%0d_busy", c),  64'(busy),  64'(e_busy));
      chk($sformatf("rnd%0d_ready", c), 64'(req_ready), 64'(e_ready));
      chk($sformatf("rnd%0d_din", c),   64'(din),   64'(e_din));
`ifdef FIFO_ARB_AFULL_EN
      blk = almost_full;
`else
      blk = 1'b0;
`endif
      if (m_owner < 0) begin
        if (req_valid != '0 && !blk) begin
          for (int k = 1; k <= NREQ && m_owner < 0; k++)
            if (req_valid[(m_last + k) % NREQ]) m_owner = (m_last + k) % NREQ;
          m_beats = 0;
        end
      end else if (!req_valid[m_owner]) begin
        m_last = m_owner; m_owner = -1;
      end else if (!full) begin
        m_beats++;
        if (m_beats == MAX_BURST) begin
          m_last = m_owner; m_owner = -1;
        end
      end
      @(posedge clk); #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4: number of requesters sharing one FIFO write port.
REQ-002 SHALL have parameter DWIDTH, default 32: data width.
REQ-003 SHALL have parameter MAX_BURST, default 4: maximum beats per grant (range 1..255).
REQ-004 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-005 SHALL have port rst_n  input  1  reset; asynchronous assert, active-low.
REQ-006 SHALL have port req_valid  input  NREQ  per-requester data valid.
REQ-007 SHALL have port req_data  input  NREQ*DWIDTH  requester i data in bits [i*DWIDTH +: DWIDTH].
REQ-008 SHALL have port req_ready  output  NREQ  per-requester beat accepted this cycle.
REQ-009 SHALL have port write  output  1  FIFO write strobe.
REQ-010 SHALL have port din  output  DWIDTH  FIFO write data.
REQ-011 SHALL have port full  input  1  FIFO full.
REQ-012 SHALL have port almost_full  input  1  FIFO almost full.
REQ-013 SHALL have port grant  output  NREQ  one-hot current owner; all zero when idle.
REQ-014 SHALL have port busy  output  1  high in state GRANT.

Function
REQ-015 SHALL implement a two-state FSM: IDLE and GRANT.
REQ-016 In IDLE with any req_valid bit set (and not blocked per REQ-027), SHALL select the first set bit searching round-robin from last_owner+1, wrapping NREQ-1 to 0, and register it into grant; move to GRANT next cycle. Arbitration latency: 1 cycle.
REQ-017 In IDLE, write and req_ready SHALL be 0.
REQ-018 In GRANT, a beat transfers when req_valid[g] and !full. That cycle, write=1, din=req_data[g] and req_ready[g]=1, all combinational. Other req_ready bits SHALL be 0.
REQ-019 din SHALL equal req_data[g] whenever in GRANT and SHALL be 0 in IDLE.
REQ-020 A beat counter SHALL increment on each transfer and SHALL clear on entry to GRANT.
REQ-021 GRANT SHALL return to IDLE at the clock edge after the transfer that brings the beat count to MAX_BURST. Grant SHALL clear and last_owner SHALL be set to g.
REQ-022 GRANT SHALL return to IDLE when req_valid[g] is low in any cycle. Grant SHALL clear, last_owner=g, and no write SHALL occur.
REQ-023 While full=1 in GRANT, the block SHALL stall: write=0, req_ready=0, and grant and counter held. Requester deassertion during the stall follows REQ-022.
REQ-024 write SHALL never assert while full=1.
REQ-025 Requesters not granted SHALL see req_ready=0 and SHALL be starved for no more than NREQ-1 grants.

Reset
REQ-026 On rst_n low, SHALL asynchronously force: state IDLE, grant=0, busy=0, write=0, req_ready=0, din=0, beat counter=0, last_owner=NREQ-1 (requester 0 wins first). Reset mid-burst SHALL abandon the burst with no further write.

Configuration
REQ-027 Macro FIFO_ARB_AFULL_EN. When defined, IDLE SHALL issue no new grant while almost_full=1, and an active burst SHALL continue, bounded only by full. When undefined, almost_full SHALL be ignored.

Verification
REQ-028 Single requester: req_valid=4'b0001 held, data 0..7, MAX_BURST=4, full=0. Required: writes of 0,1,2,3 on consecutive cycles, one IDLE cycle, then 4..7.
REQ-029 All four valid continuously from reset. Required: grant order 0001,0010,0100,1000,0001, each 4 beats, each followed by 1 IDLE cycle.
REQ-030 full=1 for 3 cycles mid-burst after beat 2. Required: write=0 for those 3 cycles, grant held, beats 3–4 follow, and no data lost or duplicated.
REQ-031 Requester 2 drops req_valid after 1 beat. Required: the next edge goes to IDLE, and the next grant goes to requester 3 if valid, otherwise 0.
REQ-032 With FIFO_ARB_AFULL_EN, almost_full=1 in IDLE with req_valid=4'b1111. Required: grant stays 0 until almost_full=0, then a grant is issued 1 cycle later. Without the macro, the grant is issued immediately.
REQ-033 rst_n pulsed low mid-burst between clock edges. Required: write, grant and busy go to 0 immediately, and after release requester 0 is granted first.
